// File: rtl/ext_unit_pipe_pkg.sv
// ext_pkg: shared types and the immediate-extension function for ext_unit_pipe.
//   ext_mode_e : extension mode encoding carried with each beat
//   occ_e      : occupancy states of the 2-entry skid buffer
//   ext_calc   : width-generic extension, computed in EXT_MAX_W bits and
//                truncated by the caller to its output width
package ext_pkg;

    localparam int EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_LUI  = 2'b01,
        EXT_BOFS = 2'b10,
        EXT_ZERO = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    // imm carries the raw immediate in its low in_w bits; higher bits are ignored.
    function automatic logic [EXT_MAX_W-1:0] ext_calc(
        input logic [EXT_MAX_W-1:0] imm,
        input ext_mode_e            mode,
        input int                   in_w,
        input int                   out_w
    );
        logic [EXT_MAX_W-1:0] mask, m, s;
        mask = (EXT_MAX_W'(1) << in_w) - EXT_MAX_W'(1);
        m    = imm & mask;
        s    = |(m & (EXT_MAX_W'(1) << (in_w - 1))) ? (m | ~mask) : m;
        return mode == EXT_LUI  ? m << (out_w - in_w) :
               mode == EXT_BOFS ? s << 2 :
               mode == EXT_ZERO ? m : s;
    endfunction

endpackage

// File: rtl/ext_unit_pipe_if.sv
// ext_unit_pipe_if: decode-side and execute-side handshake bundle of ext_unit_pipe.
//   in_valid/in_ready/in_imm/in_mode/in_tag      : upstream beat
//   out_valid/out_ready/out_data/out_tag         : downstream beat
//   master : upstream producer / downstream consumer (testbench side)
//   slave  : the extension stage itself
interface ext_unit_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/ext_unit_pipe_skid_buf2.sv
// skid_buf2: generic 2-entry valid/ready buffer with registered in_ready.
//   clk, rst_n (async, active-low), flush (sync, drops all entries)
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake, WIDTH payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake, WIDTH payload
// main_q drives the output directly; skid_q only catches the beat that arrives
// while main is stalled, so in_ready never depends on out_ready combinationally.
module skid_buf2
    import ext_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    occ_e             state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_x, out_x;

    assign in_ready_o  = state_q != OCC_TWO;
    assign out_valid_o = state_q != OCC_EMPTY;
    assign out_data_o  = main_q;
    assign in_x        = in_valid_i && in_ready_o;
    assign out_x       = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (in_x) begin
                    state_d = OCC_ONE;
                    main_d  = in_data_i;
                end
            end
            OCC_ONE: begin
                if (in_x && out_x) begin
                    main_d = in_data_i;
                end else if (in_x) begin
                    state_d = OCC_TWO;
                    skid_d  = in_data_i;
                end else if (out_x) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (out_x) begin
                    state_d = OCC_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        // Flush keeps main_q so out_data holds its last value; out_valid drops.
        if (flush) begin
            state_d = OCC_EMPTY;
            main_d  = main_q;
            skid_d  = '0;
        end
    end
endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered immediate-extension stage between decode and execute.
//   clk, rst_n (async, active-low), flush (sync, discards held beats)
//   bus (ext_unit_pipe_if.slave): in_* beat with imm/mode/tag, out_* extended data/tag
//   EXT_PERF_CNT_EN: adds perf_sel (in, 2) and perf_cnt (out, 32), one
//   delivered-beat counter per extension mode.
module ext_unit_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    ext_unit_pipe_if.slave     bus
`ifdef EXT_PERF_CNT_EN
    ,
    input  logic [1:0]         perf_sel,
    output logic [31:0]        perf_cnt
`endif
);
`ifdef EXT_PERF_CNT_EN
    localparam int MODE_W = 2;
`else
    localparam int MODE_W = 0;
`endif
    localparam int PW = OUT_W + TAG_W + MODE_W;

    if (OUT_W < IN_W + 2 || OUT_W > EXT_MAX_W) begin : g_bad_width
        $error("ext_unit_pipe: OUT_W must satisfy IN_W+2 <= OUT_W <= %0d", EXT_MAX_W);
    end

    logic [OUT_W-1:0] ext_data;
    logic [PW-1:0]    in_pl, out_pl;

    // Extension happens before the register, so the output is a pure flop.
    assign ext_data = OUT_W'(ext_calc(EXT_MAX_W'(bus.in_imm), ext_mode_e'(bus.in_mode), IN_W, OUT_W));

`ifdef EXT_PERF_CNT_EN
    logic [1:0]  out_mode;
    logic [31:0] cnt_q [4];

    assign in_pl = {ext_data, bus.in_tag, bus.in_mode};
    assign {bus.out_data, bus.out_tag, out_mode} = out_pl;
    assign perf_cnt = cnt_q[perf_sel];

    // Counts delivered beats; a delivery in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            cnt_q[out_mode] <= cnt_q[out_mode] + 32'd1;
        end
    end
`else
    assign in_pl = {ext_data, bus.in_tag};
    assign {bus.out_data, bus.out_tag} = out_pl;
`endif

    skid_buf2 #(.WIDTH(PW)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (in_pl),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_pl)
    );
endmodule
